histogram_cdf_writer: RTL and testbench

// - Downstream stage of the histogram data path. Runs once all pixels are binned in scratch memory.
// - Reads the 64 scratch words in order (256 bins x 32b, 4 bins per word) and forms the running

---
 rtl/histogram_cdf_writer_pkg.sv | 22 ++
 rtl/histogram_cdf_writer_if.sv | 28 ++
 rtl/histogram_cdf_writer_cdf_prefix4.sv | 54 +++++
 rtl/histogram_cdf_writer.sv | 150 +++++++++++++++
 tb/tb_histogram_cdf_writer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/histogram_cdf_writer_pkg.sv
// Shared constants for the histogram data path: bin/word geometry and the
// control FSM state encoding used by both the control FSM and the CDF writer.
package histogram_pkg;

    localparam int NUM_BIN_WORDS = 64;
    localparam int BINS_PER_WORD = 4;
    localparam int BIN_WIDTH     = 32;
    localparam int WORD_WIDTH    = 128;
    localparam int WORD_IDX_W    = 6;
    localparam int ADDR_W        = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(NUM_BIN_WORDS - 1);

    typedef logic [BIN_WIDTH-1:0]  bin_t;
    typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/histogram_cdf_writer_if.sv
// Memory-side bundle of the CDF writer: scratch read port and output write port.
// master = the writer, slave = the memory subsystem.
interface histogram_cdf_writer_if;
    import histogram_pkg::*;

    word_t               scratch_memory_rdata0;
    logic [ADDR_W-1:0]   scratch_memory_address_pointer0;
    logic                output_memory_write_enable;
    logic [ADDR_W-1:0]   output_memory_write_address;
    word_t               output_memory_wdata;

    modport master (
        input  scratch_memory_rdata0,
        output scratch_memory_address_pointer0,
        output output_memory_write_enable,
        output output_memory_write_address,
        output output_memory_wdata
    );

    modport slave (
        output scratch_memory_rdata0,
        input  scratch_memory_address_pointer0,
        input  output_memory_write_enable,
        input  output_memory_write_address,
        input  output_memory_wdata
    );

endinterface

// File: rtl/histogram_cdf_writer_cdf_prefix4.sv
// Combinational 4-lane saturating prefix adder: extends the running sum across
// one packed scratch word (lane 0 in the top 32 bits).
module cdf_prefix4
    import histogram_pkg::*;
(
    input  bin_t  sum_i,
    input  word_t word_i,
    input  logic  mask_i,
    output word_t cdf_o,
    output bin_t  sum_o,
    output logic  sat_o
);

    // Returns {saturated, clamped sum}; the 33rd bit of the raw add is the overflow.
    function automatic logic [BIN_WIDTH:0] sat_add(input bin_t a, input bin_t b);
        logic [BIN_WIDTH:0] raw;
        raw = {1'b0, a} + {1'b0, b};
        if (raw[BIN_WIDTH]) begin
            return {1'b1, {BIN_WIDTH{1'b1}}};
        end
        return raw;
    endfunction

    logic [BIN_WIDTH:0] lane_res [BINS_PER_WORD];
    bin_t               lane_bin [BINS_PER_WORD];
    bin_t               lane_cdf [BINS_PER_WORD];

    always_comb begin
        for (int k = 0; k < BINS_PER_WORD; k++) begin
            lane_bin[k] = mask_i ? word_i[WORD_WIDTH-1-k*BIN_WIDTH -: BIN_WIDTH] : '0;
        end
    end

    // Unwritten scratch words read as garbage, so the mask gates every lane.
    always_comb begin
        lane_res[0] = sat_add(sum_i, lane_bin[0]);
        lane_cdf[0] = lane_res[0][BIN_WIDTH-1:0];
        for (int k = 1; k < BINS_PER_WORD; k++) begin
            lane_res[k] = sat_add(lane_cdf[k-1], lane_bin[k]);
            lane_cdf[k] = lane_res[k][BIN_WIDTH-1:0];
        end
    end

    always_comb begin
        cdf_o = '0;
        sat_o = 1'b0;
        for (int k = 0; k < BINS_PER_WORD; k++) begin
            cdf_o[WORD_WIDTH-1-k*BIN_WIDTH -: BIN_WIDTH] = lane_cdf[k];
            sat_o = sat_o | lane_res[k][BIN_WIDTH];
        end
        sum_o = lane_cdf[BINS_PER_WORD-1];
    end

endmodule

// File: rtl/histogram_cdf_writer.sv
// Histogram CDF writer: streams the 64 scratch words, accumulates a saturating
// running sum across all 256 bins and writes the CDF words to output memory.
module histogram_cdf_writer
    import histogram_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] OUT_BASE     = 16'h0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_BIN_WORDS-1:0] bin_written_mask,
    histogram_cdf_writer_if.master   mem,
    output logic                     busy,
    output logic                     done,
    output bin_t                     total_count,
    output logic                     overflow
);

    logic [1:0]            state_q, state_d;
    logic [WORD_IDX_W-1:0] addr_q, addr_d;

    logic                  vld_p [READ_LATENCY];
    logic [WORD_IDX_W-1:0] idx_p [READ_LATENCY];

    logic                  we_q;
    logic [ADDR_W-1:0]     waddr_q;
    word_t                 wdata_q;
    logic [WORD_IDX_W-1:0] widx_q;
    bin_t                  sum_q;
    bin_t                  total_q;
    logic                  ovf_q;

    logic                  issue;
    logic                  accept;
    logic                  last_wr;
    logic                  ret_vld;
    logic [WORD_IDX_W-1:0] ret_idx;
    word_t                 cdf_word;
    bin_t                  cdf_sum;
    logic                  cdf_sat;

    assign issue   = (state_q == ST_ISSUE);
    assign accept  = (state_q == ST_IDLE) && start;
    assign last_wr = we_q && (widx_q == LAST_WORD);
    assign ret_vld = vld_p[READ_LATENCY-1];
    assign ret_idx = idx_p[READ_LATENCY-1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    addr_d  = '0;
                end
            end
            ST_ISSUE: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_WORD) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_wr) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    cdf_prefix4 u_prefix (
        .sum_i  (sum_q),
        .word_i (mem.scratch_memory_rdata0),
        .mask_i (bin_written_mask[ret_idx]),
        .cdf_o  (cdf_word),
        .sum_o  (cdf_sum),
        .sat_o  (cdf_sat)
    );

    // Read tag pipeline: a valid/index pair walks alongside each outstanding read.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        idx_p[0] <= addr_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            idx_p[i] <= idx_p[i-1];
        end
    end

    // Write stage: returning data is accumulated and presented the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            widx_q  <= '0;
            sum_q   <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= ret_vld;
            if (ret_vld) begin
                waddr_q <= OUT_BASE + {{(ADDR_W-WORD_IDX_W){1'b0}}, ret_idx};
                wdata_q <= cdf_word;
                widx_q  <= ret_idx;
                sum_q   <= cdf_sum;
            end
            if (accept) begin
                sum_q   <= '0;
                total_q <= '0;
                ovf_q   <= 1'b0;
            end else if (ret_vld && cdf_sat) begin
                ovf_q   <= 1'b1;
            end
            if ((state_q == ST_DRAIN) && last_wr) begin
                total_q <= sum_q;
            end
        end
    end

    assign mem.scratch_memory_address_pointer0 = {{(ADDR_W-WORD_IDX_W){1'b0}}, addr_q};
    assign mem.output_memory_write_enable      = we_q;
    assign mem.output_memory_write_address     = waddr_q;
    assign mem.output_memory_wdata             = wdata_q;

    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign total_count = total_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_histogram_cdf_writer.sv
// Scoreboard bench for histogram_cdf_writer: two instances (read latency 1 and 3)
// share stimulus; a bin-level reference model fills per-instance expectation queues.
module tb_histogram_cdf_writer;
    import histogram_pkg::*;

    typedef struct packed {
        logic [5:0]   w;
        logic [127:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   mask;
    logic [127:0]  mem_w [64];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            start_cyc = 0;
    bit            pass_active = 1'b0;
    logic [31:0]   exp_total;
    logic          exp_ovf;
    exp_t          exp_q [2][$];
    int            wr_cnt [2];
    bit            done_seen [2];

    logic [1:0]         busy_w, done_w, ovf_w, we_w;
    logic [1:0][31:0]   tot_w;
    logic [1:0][15:0]   saddr_w, waddr_w;
    logic [1:0][127:0]  wdata_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int          LAT  = (g == 0) ? 1 : 3;
        localparam logic [15:0] BASE = (g == 0) ? 16'h0000 : 16'hFFF0;

        histogram_cdf_writer_if mif ();
        logic [127:0] rpipe [LAT];

        histogram_cdf_writer #(.READ_LATENCY(LAT), .OUT_BASE(BASE)) dut (
            .clock            (clk),
            .reset            (rst),
            .start            (start),
            .bin_written_mask (mask),
            .mem              (mif),
            .busy             (busy_w[g]),
            .done             (done_w[g]),
            .total_count      (tot_w[g]),
            .overflow         (ovf_w[g])
        );

        always @(posedge clk) begin
            rpipe[0] <= mem_w[mif.scratch_memory_address_pointer0[5:0]];
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
        assign mif.scratch_memory_rdata0 = rpipe[LAT-1];

        assign we_w[g]    = mif.output_memory_write_enable;
        assign saddr_w[g] = mif.scratch_memory_address_pointer0;
        assign waddr_w[g] = mif.output_memory_write_address;
        assign wdata_w[g] = mif.output_memory_wdata;

        always @(negedge clk) begin
            int          rel;
            exp_t        e;
            logic [15:0] ea;
            rel = cyc - start_cyc;
            if (pass_active && rel >= 1 && rel <= 64)
                check($sformatf("saddr_L%0d", LAT), mif.scratch_memory_address_pointer0, 128'(rel - 1));
            if (mif.output_memory_write_enable) begin
                if (exp_q[g].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write_L%0d: got write addr %0h at cycle %0d, required none",
                             LAT, mif.output_memory_write_address, cyc);
                end else begin
                    e  = exp_q[g].pop_front();
                    ea = BASE + 16'(e.w);
                    wr_cnt[g]++;
                    check($sformatf("waddr_L%0d_w%0d", LAT, e.w), mif.output_memory_write_address, ea);
                    check($sformatf("wdata_L%0d_w%0d", LAT, e.w), mif.output_memory_wdata, e.d);
                    check($sformatf("wtime_L%0d_w%0d", LAT, e.w), 128'(rel), 128'(2 + e.w + LAT));
                end
            end
            if (done_w[g]) begin
                check($sformatf("done_time_L%0d", LAT), 128'(rel), 128'(66 + LAT));
                check($sformatf("total_L%0d", LAT), tot_w[g], exp_total);
                check($sformatf("overflow_L%0d", LAT), ovf_w[g], exp_ovf);
                check($sformatf("nwrites_L%0d", LAT), 128'(wr_cnt[g]), 128'd64);
                check($sformatf("pending_L%0d", LAT), 128'(exp_q[g].size()), 128'd0);
                done_seen[g] = 1'b1;
            end
        end
    end

    // Reference: 256 individual bins, unbounded prefix sum, clamped afterwards.
    task automatic build_expect();
        logic [63:0] acc;
        logic [31:0] cdf [256];
        logic [31:0] b;
        exp_t        e;
        acc     = '0;
        exp_ovf = 1'b0;
        for (int j = 0; j < 256; j++) begin
            b = mask[j/4] ? mem_w[j/4][127-32*(j%4) -: 32] : 32'd0;
            acc += 64'(b);
            if (acc > 64'hFFFF_FFFF) begin
                exp_ovf = 1'b1;
                cdf[j]  = 32'hFFFF_FFFF;
            end else begin
                cdf[j] = acc[31:0];
            end
        end
        exp_total = cdf[255];
        for (int w = 0; w < 64; w++) begin
            e.w = 6'(w);
            e.d = {cdf[4*w], cdf[4*w+1], cdf[4*w+2], cdf[4*w+3]};
            exp_q[0].push_back(e);
            exp_q[1].push_back(e);
        end
    endtask

    task automatic fill_garbage();
        for (int w = 0; w < 64; w++) mem_w[w] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_quiet(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_we%0d", tag, i), we_w[i], 0);
            check($sformatf("%s_busy%0d", tag, i), busy_w[i], 0);
            check($sformatf("%s_done%0d", tag, i), done_w[i], 0);
        end
    endtask

    task automatic launch();
        build_expect();
        wr_cnt    = '{0, 0};
        done_seen = '{0, 0};
        @(negedge clk);
        start       = 1'b1;
        start_cyc   = cyc;
        pass_active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("start_busy%0d", i), busy_w[i], 1);
            check($sformatf("start_total_clr%0d", i), tot_w[i], 0);
            check($sformatf("start_ovf_clr%0d", i), ovf_w[i], 0);
        end
    endtask

    task automatic run_pass(input string tag, input bit poke_mid, input bit poke_done);
        bit poked;
        poked = 1'b0;
        launch();
        for (int i = 0; i < 200 && !(done_seen[0] && done_seen[1]); i++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke_mid && cyc == start_cyc + 10) start = 1'b1;
            if (poke_done && !poked && done_w[0]) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        if (!(done_seen[0] && done_seen[1])) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got done=%0b%0b required both done within 200 cycles",
                     tag, done_seen[1], done_seen[0]);
        end
        @(negedge clk);
        start       = 1'b0;
        pass_active = 1'b0;
        repeat (3) begin
            check_quiet({tag, "_after"});
            @(negedge clk);
        end
        exp_q[0].delete();
        exp_q[1].delete();
    endtask

    task automatic reset_mid_pass();
        launch();
        while (cyc < start_cyc + 30) @(negedge clk);
        #1;
        rst = 1'b1;
        pass_active = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        @(negedge clk);
        check_quiet("rst_mid");
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_quiet("rst_mid_idle");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mask  = '0;
        fill_garbage();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_we%0d", i), we_w[i], 0);
            check($sformatf("rst_saddr%0d", i), saddr_w[i], 0);
            check($sformatf("rst_waddr%0d", i), waddr_w[i], 0);
            check($sformatf("rst_wdata%0d", i), wdata_w[i], 0);
            check($sformatf("rst_total%0d", i), tot_w[i], 0);
            check($sformatf("rst_ovf%0d", i), ovf_w[i], 0);
        end
        check_quiet("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Empty histogram: nothing marked written, scratch is junk.
        fill_garbage();
        mask = '0;
        run_pass("empty", 1'b0, 1'b0);

        // Single bin 22 (word 5, lane 2) holds 7.
        fill_garbage();
        mask = 64'd1 << 5;
        mem_w[5] = {32'd0, 32'd0, 32'd7, 32'd0};
        run_pass("single", 1'b0, 1'b0);

        // Full image 8192 pixels, with a stray start at cycle 10.
        for (int w = 0; w < 64; w++) mem_w[w] = {4{32'd32}};
        mask = '1;
        run_pass("full", 1'b1, 1'b0);

        // Saturation in word 0, plus a start during the DONE cycle.
        fill_garbage();
        mask = 64'd1;
        mem_w[0] = {32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0};
        run_pass("sat", 1'b0, 1'b1);

        // Random mask with small bins, then with full-range bins.
        fill_garbage();
        mask = {$urandom, $urandom};
        for (int w = 0; w < 64; w++)
            mem_w[w] = {32'($urandom_range(0, 1000)), 32'($urandom_range(0, 1000)),
                        32'($urandom_range(0, 1000)), 32'($urandom_range(0, 1000))};
        run_pass("rand_small", 1'b0, 1'b0);

        fill_garbage();
        mask = {$urandom, $urandom};
        mem_w[0] = {32'd0, 32'd0, 32'd0, 32'($urandom_range(0, 255))};
        run_pass("rand_big", 1'b0, 1'b0);

        // Reset partway through, then a clean pass from word 0.
        fill_garbage();
        mask = '1;
        reset_mid_pass();
        for (int w = 0; w < 64; w++)
            mem_w[w] = {32'($urandom_range(0, 50)), 32'($urandom_range(0, 50)),
                        32'($urandom_range(0, 50)), 32'($urandom_range(0, 50))};
        run_pass("after_rst", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
